// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR filter.
// Holds the controller state encoding, accumulator sizing and saturation limits.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND,
        OUT
    } state_t;

    // Sized so that TAPS full-scale products can be summed without overflow.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample delay line: writes advance wr_ptr, reads return the sample
// written k positions before the newest one.
module fir_sample_ring #(
    parameter  int DW   = 32,
    parameter  int TAPS = 40,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] k,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [TAPS];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] head;
    logic [AW-1:0] rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            head   <= '0;
        end else if (we) begin
            mem[wr_ptr] <= wdata;
            head        <= wr_ptr;
            wr_ptr      <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    // head - k wraps through TAPS; the AW-bit sum lands in range for any TAPS.
    always_comb begin
        rd_idx = head - k;
        if (head < k) begin
            rd_idx = head - k + AW'(TAPS);
        end
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/fir_mac_tdm.sv
// Time-multiplexed FIR: one multiply-accumulate per tap, then rounding and
// signed saturation, with run-time loadable coefficients.
module fir_mac_tdm
    import fir_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int CW    = 16,
    parameter  int TAPS  = 40,
    parameter  int SHIFT = 15,
    localparam int AW    = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic          coef_err,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          sat_flag,
    output logic          busy
);

    localparam int ACC_W = acc_width(DW, CW, TAPS);
    localparam int RW    = ACC_W + 1;
    localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] ROUND_ADD = (SHIFT > 0) ? (RW'(1) <<< RSH) : '0;
    localparam logic signed [RW-1:0] MAXV      = RW'(sat_max(DW));
    localparam logic signed [RW-1:0] MINV      = RW'(sat_min(DW));

    state_t                     state;
    state_t                     next_state;
    logic        [AW-1:0]       k;
    logic signed [ACC_W-1:0]    acc;
    logic signed [RW-1:0]       r;
    logic signed [CW-1:0]       coef [TAPS];
    logic signed [DW-1:0]       x_k;
    logic signed [DW+CW-1:0]    prod;
    logic                       ready_en;
    logic                       accept;
    logic                       coef_ok;
    logic        [DW-1:0]       sat_val;
    logic                       sat_hit;

    fir_sample_ring #(
        .DW   (DW),
        .TAPS (TAPS)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .wdata (in_data),
        .k     (k),
        .rdata (x_k)
    );

    // ready_en keeps in_ready low until the first edge after reset release.
    assign in_ready = (state == IDLE) && ready_en;
    assign accept   = in_ready && in_valid;
    assign busy     = (state != IDLE);
    assign coef_ok  = (state == IDLE) && (int'(coef_addr) < TAPS);
    assign prod     = (DW+CW)'(x_k) * (DW+CW)'(coef[k]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = MAC;
            MAC:     if (k == AW'(TAPS - 1)) next_state = ROUND;
            ROUND:   next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sat_val = r[DW-1:0];
        sat_hit = 1'b0;
        if (r > MAXV) begin
            sat_val = MAXV[DW-1:0];
            sat_hit = 1'b1;
        end else if (r < MINV) begin
            sat_val = MINV[DW-1:0];
            sat_hit = 1'b1;
        end
    end

    // A coefficient written alongside an accepted sample is visible from the
    // first MAC cycle, so that sample already uses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
            k         <= '0;
            acc       <= '0;
            r         <= '0;
            ready_en  <= 1'b0;
            coef_err  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            coef_err  <= 1'b0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            if (coef_we) begin
                if (coef_ok) begin
                    coef[coef_addr] <= coef_wdata;
                end else begin
                    coef_err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    k   <= (k == AW'(TAPS - 1)) ? '0 : k + 1'b1;
                end
                ROUND: begin
                    r <= (RW'(acc) + ROUND_ADD) >>> SHIFT;
                end
                OUT: begin
                    out_data  <= sat_val;
                    out_valid <= 1'b1;
                    sat_flag  <= sat_hit;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_tdm.sv
// Directed bench: a small 16-bit/4-tap instance for impulse, saturation and
// coefficient errors; a default instance for rounding, reset and streaming.
module tb_fir_mac_tdm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic        a_in_valid, a_in_ready, a_coef_we, a_coef_err;
    logic        a_out_valid, a_sat_flag, a_busy;
    logic [15:0] a_in_data, a_coef_wdata, a_out_data;
    logic [1:0]  a_coef_addr;

    logic        d_in_valid, d_in_ready, d_coef_we, d_coef_err;
    logic        d_out_valid, d_sat_flag, d_busy;
    logic [31:0] d_in_data, d_out_data;
    logic [15:0] d_coef_wdata;
    logic [5:0]  d_coef_addr;

    int          xs [100];
    shortint     hs [40];
    logic [31:0] expData [100];
    logic        expSat [100];
    logic [31:0] tmp;
    longint      accM;
    longint      rr;
    int          acceptEdge;
    int          prevAccept;
    int          waitCnt;
    int          staleCnt;

    fir_mac_tdm #(.DW(16), .CW(16), .TAPS(4), .SHIFT(0)) u_small (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .coef_we    (a_coef_we),
        .coef_addr  (a_coef_addr),
        .coef_wdata (a_coef_wdata),
        .coef_err   (a_coef_err),
        .out_valid  (a_out_valid),
        .out_data   (a_out_data),
        .sat_flag   (a_sat_flag),
        .busy       (a_busy)
    );

    fir_mac_tdm u_dflt (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d_in_valid),
        .in_ready   (d_in_ready),
        .in_data    (d_in_data),
        .coef_we    (d_coef_we),
        .coef_addr  (d_coef_addr),
        .coef_wdata (d_coef_wdata),
        .coef_err   (d_coef_err),
        .out_valid  (d_out_valid),
        .out_data   (d_out_data),
        .sat_flag   (d_sat_flag),
        .busy       (d_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeCoefA(input logic [1:0] addr, input logic [15:0] val);
        a_coef_we = 1'b1; a_coef_addr = addr; a_coef_wdata = val;
        @(negedge clk);
        a_coef_we = 1'b0;
    endtask

    task automatic writeCoefD(input logic [5:0] addr, input logic [15:0] val);
        d_coef_we = 1'b1; d_coef_addr = addr; d_coef_wdata = val;
        @(negedge clk);
        d_coef_we = 1'b0;
    endtask

    task automatic applyStimulusA(input logic [15:0] x);
        int t = 0;
        while (!a_in_ready && t < 50) begin @(negedge clk); t++; end
        if (!a_in_ready) checkOutput("a_ready_timeout", 64'(a_in_ready), 64'(1));
        a_in_valid = 1'b1; a_in_data = x;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic applyStimulusD(input logic [31:0] x);
        int t = 0;
        while (!d_in_ready && t < 100) begin @(negedge clk); t++; end
        if (!d_in_ready) checkOutput("d_ready_timeout", 64'(d_in_ready), 64'(1));
        d_in_valid = 1'b1; d_in_data = x;
        @(negedge clk);
        d_in_valid = 1'b0;
    endtask

    task automatic expectA(input string tag, input logic [15:0] data, input logic sat);
        int t = 0;
        while (!a_out_valid && t < 50) begin @(negedge clk); t++; end
        checkOutput({tag, "_valid"}, 64'(a_out_valid), 64'(1));
        checkOutput({tag, "_data"}, 64'(a_out_data), 64'(data));
        checkOutput({tag, "_sat"}, 64'(a_sat_flag), 64'(sat));
        @(negedge clk);
    endtask

    task automatic expectD(input string tag, input logic [31:0] data, input logic sat);
        int t = 0;
        while (!d_out_valid && t < 100) begin @(negedge clk); t++; end
        checkOutput({tag, "_valid"}, 64'(d_out_valid), 64'(1));
        checkOutput({tag, "_data"}, 64'(d_out_data), 64'(data));
        checkOutput({tag, "_sat"}, 64'(d_sat_flag), 64'(sat));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_coef_we = 1'b0; a_coef_addr = '0; a_coef_wdata = '0;
        d_in_valid = 1'b0; d_in_data = '0; d_coef_we = 1'b0; d_coef_addr = '0; d_coef_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 64'(d_in_ready), 64'(0));
        checkOutput("rst_busy", 64'(d_busy), 64'(0));
        checkOutput("rst_out_valid", 64'(d_out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(a_out_data), 64'(0));
        rst = 1'b0;
        #1 checkOutput("release_ready_low", 64'(d_in_ready), 64'(0));
        @(negedge clk);
        checkOutput("release_ready_high", 64'(d_in_ready), 64'(1));

        // impulse through h = 1,2,3,4
        writeCoefA(2'd0, 16'd1);
        checkOutput("coef_ok_no_err", 64'(a_coef_err), 64'(0));
        writeCoefA(2'd1, 16'd2);
        writeCoefA(2'd2, 16'd3);
        writeCoefA(2'd3, 16'd4);
        applyStimulusA(16'd1); expectA("imp0", 16'd1, 1'b0);
        applyStimulusA(16'd0); expectA("imp1", 16'd2, 1'b0);
        applyStimulusA(16'd0); expectA("imp2", 16'd3, 1'b0);
        applyStimulusA(16'd0); expectA("imp3", 16'd4, 1'b0);
        applyStimulusA(16'd0); expectA("imp4", 16'd0, 1'b0);

        // saturation with all h = 0x7FFF
        for (int i = 0; i < 4; i++) writeCoefA(2'(i), 16'h7FFF);
        applyStimulusA(16'h7FFF); expectA("sat_pos", 16'h7FFF, 1'b1);
        applyStimulusA(16'h8000); expectA("sat_mid", 16'h8001, 1'b0);
        applyStimulusA(16'h8000); expectA("sat_neg", 16'h8000, 1'b1);

        // coefficient write while busy must be dropped
        applyStimulusA(16'd0);
        a_coef_we = 1'b1; a_coef_addr = 2'd1; a_coef_wdata = 16'd0;
        @(negedge clk);
        a_coef_we = 1'b0;
        checkOutput("busy_coef_err", 64'(a_coef_err), 64'(1));
        @(negedge clk);
        checkOutput("busy_coef_err_pulse", 64'(a_coef_err), 64'(0));
        expectA("busy_coef_kept", 16'h8000, 1'b1);

        // rounding at SHIFT=15 with h[0] = 0.5
        writeCoefD(6'd0, 16'h4000);
        applyStimulusD(32'd3);          expectD("rnd_p3", 32'd2, 1'b0);
        applyStimulusD(-32'sd3);        expectD("rnd_m3", 32'hFFFF_FFFF, 1'b0);
        applyStimulusD(32'd2);          expectD("rnd_p2", 32'd1, 1'b0);

        d_coef_we = 1'b1; d_coef_addr = 6'd40; d_coef_wdata = 16'h1234;
        @(negedge clk);
        d_coef_we = 1'b0;
        checkOutput("addr_range_err", 64'(d_coef_err), 64'(1));
        @(negedge clk);
        checkOutput("addr_range_err_pulse", 64'(d_coef_err), 64'(0));

        // reset in the middle of a MAC
        applyStimulusD(32'd5);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(d_busy), 64'(0));
        checkOutput("midrst_ready", 64'(d_in_ready), 64'(0));
        checkOutput("midrst_out_data", 64'(d_out_data), 64'(0));
        repeat (3) @(negedge clk);
        checkOutput("midrst_out_valid", 64'(d_out_valid), 64'(0));
        rst = 1'b0;
        #1 checkOutput("midrst_release_low", 64'(d_in_ready), 64'(0));
        @(negedge clk);
        checkOutput("midrst_release_high", 64'(d_in_ready), 64'(1));
        staleCnt = 0;
        for (int t = 0; t < 60; t++) begin
            if (d_out_valid) staleCnt++;
            @(negedge clk);
        end
        checkOutput("midrst_no_stale", 64'(staleCnt), 64'(0));

        // 100 back-to-back samples against a direct-form reference
        for (int k = 0; k < 40; k++) begin
            hs[k] = shortint'(k * 2731 - 30000);
            writeCoefD(6'(k), hs[k]);
        end
        for (int i = 0; i < 100; i++) begin
            tmp = 32'(i) * 32'h9E37_79B1;
            xs[i] = int'(tmp) >>> (i % 20);
        end
        for (int i = 0; i < 100; i++) begin
            accM = 0;
            for (int k = 0; k < 40; k++) begin
                if (i - k >= 0) accM = accM + longint'(xs[i-k]) * longint'(hs[k]);
            end
            rr = (accM + 64'sd16384) >>> 15;
            if (rr > 64'sd2147483647) begin
                expData[i] = 32'h7FFF_FFFF; expSat[i] = 1'b1;
            end else if (rr < -64'sd2147483648) begin
                expData[i] = 32'h8000_0000; expSat[i] = 1'b1;
            end else begin
                expData[i] = rr[31:0]; expSat[i] = 1'b0;
            end
        end
        prevAccept = 0;
        d_in_data = xs[0];
        d_in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            waitCnt = 0;
            while (!d_in_ready && waitCnt < 60) begin @(negedge clk); waitCnt++; end
            checkOutput("stream_ready", 64'(d_in_ready), 64'(1));
            acceptEdge = cyc + 1;
            if (i > 0) checkOutput("stream_interval", 64'(acceptEdge - prevAccept), 64'(43));
            prevAccept = acceptEdge;
            @(negedge clk);
            d_in_data = (i < 99) ? xs[i+1] : 32'd0;
            waitCnt = 0;
            while (!d_out_valid && waitCnt < 60) begin @(negedge clk); waitCnt++; end
            if (i == 99) d_in_valid = 1'b0;
            checkOutput("stream_valid", 64'(d_out_valid), 64'(1));
            checkOutput("stream_latency", 64'(cyc - acceptEdge), 64'(42));
            checkOutput("stream_data", 64'(d_out_data), 64'(expData[i]));
            checkOutput("stream_sat", 64'(d_sat_flag), 64'(expSat[i]));
        end
        d_in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_tdm.md
Name: fir_mac_tdm

Overview:
Parametrised, time-multiplexed FIR filter and successor to the fixed 40-tap fir40_min. It computes one output per accepted sample using a single multiply-accumulate iterated over TAPS cycles. It adds run-time loadable coefficients, a valid/ready input handshake, round-half-up output scaling and signed saturation. It sits between the sample source (data_in path) and downstream display/processing logic.

Parameters:
DW, 32, signed sample and output width
CW, 16, signed coefficient width
TAPS, 40, number of filter taps (>=2)
SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (0 = no scaling)
AW, $clog2(TAPS), coefficient address width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample
in_data  input  DW  signed input sample
coef_we  input  1  coefficient write strobe
coef_addr  input  AW  coefficient index k (h[k] multiplies x[n-k])
coef_wdata  input  CW  signed coefficient
coef_err  output  1  one-cycle pulse: coefficient write rejected
out_valid  output  1  one-cycle pulse: out_data updated
out_data  output  DW  signed filtered result, held until next result
sat_flag  output  1  valid with out_valid: result was clipped
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time, including mid-MAC): state=IDLE; delay line, coefficients, accumulator, write pointer all cleared to 0. out_valid=0, out_data=0, sat_flag=0, coef_err=0, busy=0. in_ready=0 while rst is high and 1 from the first clock after release. Any in-flight result is discarded; no out_valid is produced for it.
- FSM states: IDLE, MAC, ROUND, OUT.
  - IDLE: in_ready=1. When in_valid=1, write the sample at wr_ptr, clear acc, set k=0 and go to MAC.
  - MAC: in_ready=0. For TAPS cycles: acc += x[n-k]*h[k], k++. After k=TAPS-1, go to ROUND.
  - ROUND: compute r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, then go to OUT.
  - OUT: register sat(r) into out_data, pulse out_valid and sat_flag, then go to IDLE.
- Latency: sample accepted at edge T produces out_valid high in the cycle following edge T+TAPS+2 (42 cycles after acceptance at TAPS=40). Throughput is one sample per TAPS+3 cycles.
- No output backpressure; out_valid is a pulse. in_valid while in_ready=0 is ignored; the source must hold the sample.
- Delay line: circular buffer of TAPS x DW. wr_ptr wraps TAPS-1 -> 0. Read index is (wr_ptr_of_current_sample - k) mod TAPS.
- Widths: product DW+CW; accumulator ACC_W = DW+CW+$clog2(TAPS), which cannot overflow. Rounding is done at ACC_W+1 bits.
- Saturation: r > 2^(DW-1)-1 gives max; r < -2^(DW-1) gives min. sat_flag=1 only in the out_valid cycle where clipping occurred.
- Coefficient write:
  - Accepted only in IDLE with coef_addr<TAPS, written at the next edge.
  - coef_we while busy, or with coef_addr>=TAPS, is dropped and coef_err pulses for 1 cycle.
  - Simultaneous in_valid and coef_we in IDLE: both take effect, and the new coefficient is used by that sample's MAC.

Decomposition:
- Package fir_pkg: state enum (IDLE/MAC/ROUND/OUT), function acc_width(DW,CW,TAPS), functions for the signed max/min saturation constants.
- Sub-module fir_sample_ring: circular delay line with write port, wr_ptr and modulo read-index port. Reset clears it.

Test Plan:
- Reset: assert rst for 3 cycles mid-stream -> out_valid=0, out_data=0, busy=0, in_ready=0 during rst and 1 one cycle after release; no stale output afterwards.
- Impulse (TAPS=4, SHIFT=0, h=1,2,3,4): inputs 1,0,0,0,0 -> out_data 1,2,3,4,0; sat_flag=0 throughout.
- Latency/throughput (defaults): back-to-back in_valid -> first out_valid 42 cycles after acceptance; in_ready high once every 43 cycles; wr_ptr wraps correctly across 100 samples (compared against a golden model).
- Saturation (DW=16, CW=16, SHIFT=0, all h=0x7FFF): step of 0x7FFF -> out_data=0x7FFF with sat_flag=1; step of 0x8000 -> out_data=0x8000 with sat_flag=1.
- Rounding (TAPS=2, SHIFT=1, h=1,0): input 3 -> 2; input -3 -> -1; input 2 -> 1.
- Coefficient errors: coef_we during MAC -> coef_err pulse and coefficient unchanged (next output unaffected); coef_addr=TAPS in IDLE -> coef_err pulse.
